prog_sequencer: RTL and testbench

- Batch controller for the single-cycle CPU core. Runs a fixed list of programs back to back: holds the core in reset, presents each program's start PC, releases reset, waits for the core's done, then records the cycle count.
- Sits between the top-level bench/host interface and the core's reset and start-PC inputs. It replaces hand-sequenced reset pulses between program 1, 2 and 3 runs.

---
 rtl/prog_sequencer.sv | 157 +++++++++++++++
 tb/tb_prog_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_sequencer.sv
// Batch controller for the single-cycle core: holds the core in reset, loads each
// program's start PC, releases it, waits for done (or timeout) and reports the cycle count.
module prog_sequencer #(
    parameter int unsigned NUM_PROG = 3,
    parameter int unsigned PC_W     = 8,
    parameter int unsigned CT_W     = 16,
    parameter int unsigned HOLD_CYC = 2,
    parameter int unsigned TIMEOUT  = 16'hFFFF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [NUM_PROG*PC_W-1:0] prog_pc_flat,
    input  logic                     core_done,
    output logic                     core_reset,
    output logic [PC_W-1:0]          core_start_pc,
    output logic [1:0]               prog_idx,
    output logic [CT_W-1:0]          cycle_ct,
    output logic                     ct_valid,
    output logic                     busy,
    output logic                     all_done,
    output logic                     timeout_err
);

    localparam int unsigned HC_W      = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HC_W-1:0] HOLD_LOAD = HC_W'(HOLD_CYC - 1);
    localparam logic [1:0]      LAST_IDX  = 2'(NUM_PROG - 1);
    localparam logic [CT_W-1:0] CT_MAX    = '1;
    localparam logic [CT_W-1:0] TO_VAL    = CT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_RUN,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [HC_W-1:0]   hold_q, hold_d;
    logic [1:0]        idx_q, idx_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [CT_W-1:0]   ct_q, ct_d;
    logic              terr_q, terr_d;
    logic              core_reset_q, core_reset_d;
    logic              ct_valid_q, ct_valid_d;
    logic              busy_q, busy_d;
    logic              all_done_q, all_done_d;

    logic [1:0]        idx_nxt;
    int unsigned       pc_sel;
    logic [PC_W-1:0]   pc_pick;
    logic [CT_W-1:0]   ct_inc;
    logic              done_ok;

    // PC to load: slot 0 at batch start, the following slot when leaving DRAIN
    assign idx_nxt = idx_q + 2'd1;
    assign pc_sel  = (state_q == S_DRAIN && idx_q != LAST_IDX) ? 32'(idx_nxt) : 32'd0;
    assign pc_pick = prog_pc_flat[pc_sel*PC_W +: PC_W];

    // A zero count marks the first RUN cycle, where a stale done is ignored
    assign ct_inc  = (ct_q == CT_MAX) ? ct_q : ct_q + 1'b1;
    assign done_ok = core_done && (ct_q != '0);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        pc_d    = pc_q;
        ct_d    = ct_q;
        terr_d  = terr_q;

        case (state_q)
            S_IDLE, S_FINISH: begin
                if (start) begin
                    state_d = S_HOLD;
                    hold_d  = HOLD_LOAD;
                    idx_d   = 2'd0;
                    pc_d    = pc_pick;
                    ct_d    = '0;
                    terr_d  = 1'b0;
                end
            end
            S_HOLD: begin
                if (hold_q == '0) begin
                    state_d = S_RUN;
                    ct_d    = '0;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            S_RUN: begin
                ct_d = ct_inc;
                // An accepted done in the timeout cycle takes priority over the error
                if (done_ok) begin
                    state_d = S_DRAIN;
                end else if (ct_inc == TO_VAL) begin
                    state_d = S_DRAIN;
                    terr_d  = 1'b1;
                end
            end
            S_DRAIN: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_FINISH;
                end else begin
                    state_d = S_HOLD;
                    hold_d  = HOLD_LOAD;
                    idx_d   = idx_nxt;
                    pc_d    = pc_pick;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status outputs are registered copies of the next-state decode
        core_reset_d = (state_d != S_RUN);
        ct_valid_d   = (state_d == S_DRAIN);
        busy_d       = (state_d == S_HOLD) || (state_d == S_RUN) || (state_d == S_DRAIN);
        all_done_d   = (state_d == S_FINISH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            hold_q       <= '0;
            idx_q        <= 2'd0;
            pc_q         <= '0;
            ct_q         <= '0;
            terr_q       <= 1'b0;
            core_reset_q <= 1'b1;
            ct_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            all_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            idx_q        <= idx_d;
            pc_q         <= pc_d;
            ct_q         <= ct_d;
            terr_q       <= terr_d;
            core_reset_q <= core_reset_d;
            ct_valid_q   <= ct_valid_d;
            busy_q       <= busy_d;
            all_done_q   <= all_done_d;
        end
    end

    assign core_reset    = core_reset_q;
    assign core_start_pc = pc_q;
    assign prog_idx      = idx_q;
    assign cycle_ct      = ct_q;
    assign ct_valid      = ct_valid_q;
    assign busy          = busy_q;
    assign all_done      = all_done_q;
    assign timeout_err   = terr_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: two instances (long and short timeout) checked every cycle
// against a batch-level model, plus table-driven run reports and directed corner cases.
module tb_prog_sequencer;

    localparam int NP   = 3;
    localparam int HOLD = 2;
    localparam int TO_NOM   = 65535;
    localparam int TO_SHORT = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [23:0] pc_flat;
    logic        dn   [2];
    logic        cr   [2];
    logic [7:0]  spc  [2];
    logic [1:0]  pidx [2];
    logic [15:0] cct  [2];
    logic        cv   [2];
    logic        bz   [2];
    logic        ad   [2];
    logic        te   [2];

    always #5 clk = ~clk;

    prog_sequencer #(.NUM_PROG(NP), .PC_W(8), .CT_W(16), .HOLD_CYC(HOLD), .TIMEOUT(TO_NOM)) u_nom (
        .clk(clk), .reset(rst), .start(start), .prog_pc_flat(pc_flat), .core_done(dn[0]),
        .core_reset(cr[0]), .core_start_pc(spc[0]), .prog_idx(pidx[0]), .cycle_ct(cct[0]),
        .ct_valid(cv[0]), .busy(bz[0]), .all_done(ad[0]), .timeout_err(te[0]));

    prog_sequencer #(.NUM_PROG(NP), .PC_W(8), .CT_W(16), .HOLD_CYC(HOLD), .TIMEOUT(TO_SHORT)) u_to (
        .clk(clk), .reset(rst), .start(start), .prog_pc_flat(pc_flat), .core_done(dn[1]),
        .core_reset(cr[1]), .core_start_pc(spc[1]), .prog_idx(pidx[1]), .cycle_ct(cct[1]),
        .ct_valid(cv[1]), .busy(bz[1]), .all_done(ad[1]), .timeout_err(te[1]));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Batch-level model: reset window countdown, run length, drain flag
    typedef struct {
        bit in_batch;
        bit fin;
        bit drain;
        int hold_left;
        int idx;
        int pc;
        int ct;
        bit terr;
    } mdl_t;

    mdl_t m [2];

    function automatic int to_of(input int i);
        return (i == 0) ? TO_NOM : TO_SHORT;
    endfunction

    function automatic mdl_t model_next(input mdl_t s, input int to, input bit st, input bit dn_i,
                                        input logic [23:0] pcs);
        mdl_t r = s;
        int   n;
        bit   acc;
        if (!r.in_batch) begin
            if (st) begin
                r.in_batch = 1; r.fin = 0; r.idx = 0; r.pc = int'(pcs[7:0]);
                r.terr = 0; r.ct = 0; r.hold_left = HOLD;
            end
        end else if (r.drain) begin
            r.drain = 0;
            if (r.idx == NP - 1) begin
                r.in_batch = 0; r.fin = 1;
            end else begin
                r.idx++;
                r.pc = int'(pcs[r.idx*8 +: 8]);
                r.hold_left = HOLD;
            end
        end else if (r.hold_left > 0) begin
            r.hold_left--;
            if (r.hold_left == 0) r.ct = 0;
        end else begin
            n = (r.ct < 65535) ? r.ct + 1 : r.ct;
            r.ct = n;
            acc = dn_i && (n >= 2);
            if (acc || n == to) begin
                if (!acc) r.terr = 1;
                r.drain = 1;
            end
        end
        return r;
    endfunction

    function automatic logic [63:0] exp_of(input mdl_t s);
        logic running;
        running = s.in_batch && !s.drain && (s.hold_left == 0);
        return 64'({~running, 8'(s.pc), 2'(s.idx), 16'(s.ct), s.drain, s.in_batch, s.fin, s.terr});
    endfunction

    function automatic logic [63:0] obs_of(input int i);
        return 64'({cr[i], spc[i], pidx[i], cct[i], cv[i], bz[i], ad[i], te[i]});
    endfunction

    localparam logic [63:0] RESET_OBS = 64'({1'b1, 8'h00, 2'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0});

    // Core-model stimulus controls and monitors
    typedef struct {
        int idx;
        int ct;
        int pc;
        bit terr;
    } ev_t;

    int   mode    [2];
    int   plan    [2][3];
    int   run_cyc [2];
    ev_t  q_nom [$];
    ev_t  q_to  [$];
    int   gaps  [$];
    int   gap = 0;

    logic        cap_rst, cap_st;
    logic [23:0] cap_pc;
    logic        cap_dn [2];

    always @(posedge clk) begin
        cap_rst = rst; cap_st = start; cap_pc = pc_flat;
        cap_dn[0] = dn[0]; cap_dn[1] = dn[1];
        #1;
        for (int i = 0; i < 2; i++) begin
            if (cap_rst) m[i] = '{default: 0};
            else m[i] = model_next(m[i], to_of(i), cap_st, cap_dn[i], cap_pc);
            check($sformatf("cycle_u%0d", i), obs_of(i), exp_of(m[i]));
            if (cv[i]) begin
                if (i == 0) q_nom.push_back('{int'(pidx[i]), int'(cct[i]), int'(spc[i]), te[i]});
                else        q_to.push_back('{int'(pidx[i]), int'(cct[i]), int'(spc[i]), te[i]});
            end
            if (cr[i]) run_cyc[i] = 0;
            else       run_cyc[i]++;
            case (mode[i])
                0: dn[i] = !cr[i] && plan[i][pidx[i]] != 0 && run_cyc[i] == plan[i][pidx[i]];
                1: dn[i] = 1'b1;
                default: dn[i] = cr[i] ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 5) == 0);
            endcase
        end
        if (bz[0] && cr[0]) gap++;
        else begin
            if (!cr[0] && gap > 0) gaps.push_back(gap);
            gap = 0;
        end
    end

    task automatic wait_all_done(input int budget, input string nm);
        int k = 0;
        while (!(ad[0] && ad[1]) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(nm, 64'(ad[0] && ad[1]), 64'd1);
    endtask

    typedef struct {
        int d_nom;
        int d_to;
        int idx;
        int pc;
        int ct_nom;
        int ct_to;
        bit terr_to;
    } vec_t;

    vec_t tbl  [3];
    int   stale_ct [2];

    initial begin
        tbl[0] = '{10, 10, 0, 'h00, 10, 10, 1'b0};
        tbl[1] = '{25,  0, 1, 'h40, 25, 20, 1'b1};
        tbl[2] = '{ 7,  7, 2, 'h80,  7,  7, 1'b1};
        stale_ct[0] = 2;
        stale_ct[1] = 20;

        rst = 1'b1; start = 1'b0; pc_flat = {8'h80, 8'h40, 8'h00};
        for (int i = 0; i < 2; i++) begin
            dn[i] = 1'b0; mode[i] = 0; run_cyc[i] = 0; m[i] = '{default: 0};
        end
        repeat (3) @(negedge clk);
        check("reset_nom", obs_of(0), RESET_OBS);
        check("reset_to", obs_of(1), RESET_OBS);
        rst = 1'b0;

        // Nominal batch; short-timeout instance never sees done for program 1
        for (int p = 0; p < NP; p++) begin
            plan[0][p] = tbl[p].d_nom;
            plan[1][p] = tbl[p].d_to;
        end
        q_nom.delete(); q_to.delete(); gaps.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_all_done(400, "nominal_done");
        check("nom_events", 64'(q_nom.size()), 64'(NP));
        check("to_events", 64'(q_to.size()), 64'(NP));
        for (int p = 0; p < NP; p++) begin
            if (p < q_nom.size()) begin
                check($sformatf("nom_idx%0d", p), 64'(q_nom[p].idx), 64'(tbl[p].idx));
                check($sformatf("nom_ct%0d", p), 64'(q_nom[p].ct), 64'(tbl[p].ct_nom));
                check($sformatf("nom_pc%0d", p), 64'(q_nom[p].pc), 64'(tbl[p].pc));
                check($sformatf("nom_terr%0d", p), 64'(q_nom[p].terr), 64'd0);
            end
            if (p < q_to.size()) begin
                check($sformatf("to_ct%0d", p), 64'(q_to[p].ct), 64'(tbl[p].ct_to));
                check($sformatf("to_terr%0d", p), 64'(q_to[p].terr), 64'(tbl[p].terr_to));
            end
        end
        check("gap_count", 64'(gaps.size()), 64'(NP));
        for (int g = 0; g < gaps.size(); g++)
            check($sformatf("gap%0d", g), 64'(gaps[g]), 64'((g == 0) ? HOLD : HOLD + 1));

        // Restart from FINISH: all_done drops and timeout_err clears one cycle later
        check("finish_all_done", 64'(ad[1]), 64'd1);
        check("finish_terr_sticky", 64'(te[1]), 64'd1);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("restart_all_done", 64'({ad[0], ad[1]}), 64'd0);
        check("restart_terr", 64'(te[1]), 64'd0);
        check("restart_busy", 64'({bz[0], bz[1]}), 64'd3);

        // Asynchronous reset in the middle of program 1's run
        begin
            int k = 0;
            while (!(pidx[0] == 2'd1 && !cr[0]) && k < 200) begin
                @(negedge clk);
                k++;
            end
            check("reach_run1", 64'(pidx[0] == 2'd1 && !cr[0]), 64'd1);
        end
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_nom", obs_of(0), RESET_OBS);
        check("async_rst_to", obs_of(1), RESET_OBS);
        @(negedge clk); rst = 1'b0;

        // Stale done held high, and done coinciding with the timeout cycle
        mode[0] = 1;
        for (int p = 0; p < NP; p++) plan[1][p] = 20;
        pc_flat = {8'h33, 8'h22, 8'h11};
        q_nom.delete(); q_to.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("post_rst_idx", 64'(pidx[0]), 64'd0);
        check("post_rst_pc", 64'(spc[0]), 64'h11);
        wait_all_done(400, "stale_done");
        check("stale_events", 64'(q_nom.size() + q_to.size()), 64'(2 * NP));
        for (int p = 0; p < NP; p++) begin
            if (p < q_nom.size())
                check($sformatf("stale_ct%0d", p), 64'(q_nom[p].ct), 64'(stale_ct[0]));
            if (p < q_to.size()) begin
                check($sformatf("tie_ct%0d", p), 64'(q_to[p].ct), 64'(stale_ct[1]));
                check($sformatf("tie_terr%0d", p), 64'(q_to[p].terr), 64'd0);
            end
        end

        // Randomized traffic checked cycle by cycle against the model
        mode[0] = 2; mode[1] = 2;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            start = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 15) == 0) pc_flat = 24'($urandom);
            rst = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
